// File: rtl/hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// hazard_detection_unit
//   ID-stage hazard detector for the 5-stage 16-bit pipeline. It keeps a
//   shadow copy of the instructions sitting in EX and MEM and decides, in the
//   same cycle, whether ID must stall, whether IF/ID must be flushed after a
//   taken branch, and whether the whole pipe must freeze on a cache miss.
//   It covers the hazards that EX-stage forwarding cannot: load-use, branches
//   resolved in ID (B on flags, BR on rs), cache-miss freeze and HLT.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_valid          IF/ID holds a real instruction
//   id_opcode         ID opcode
//   id_rs/id_rt/id_rd ID register fields (id_rd is also SW data / LLB,LHB source)
//   id_cond           B condition code, 3'b111 = unconditional
//   id_br_taken       ID branch resolved taken this cycle
//   icache_miss       fetch miss pending
//   dcache_miss       MEM-stage miss pending
//   pc_write          PC update enable
//   ifid_write        IF/ID register enable
//   idex_bubble       load a NOP into ID/EX instead of the ID instruction
//   ifid_flush        squash IF/ID contents at the next edge
//   pipe_freeze       hold every pipeline register
//   halted            HLT has reached ID, fetch stopped
//   stall_cnt         saturating count of cycles with idex_bubble=1
//   freeze_cnt        saturating count of cycles with pipe_freeze=1
// ---------------------------------------------------------------------------
module hazard_detection_unit #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic [2:0]       id_cond,
    input  logic             id_br_taken,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_RED    = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_SLL    = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_SRA    = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_ROR    = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_PADDSB = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_LW     = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_SW     = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_LLB    = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_LHB    = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_B      = OP_W'(4'hC);
    localparam logic [OP_W-1:0] OP_BR     = OP_W'(4'hD);
    localparam logic [OP_W-1:0] OP_PCS    = OP_W'(4'hE);
    localparam logic [OP_W-1:0] OP_HLT    = OP_W'(4'hF);

    localparam logic [REG_W-1:0] R0      = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    // ---------------- opcode decode helpers ----------------
    function automatic logic reads_rs(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
            OP_LW, OP_SW, OP_BR: reads_rs = 1'b1;
            default:             reads_rs = 1'b0;
        endcase
    endfunction

    // Shifts/rotates carry an immediate in the rt field, so they do not read rt.
    function automatic logic reads_rt(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: reads_rt = 1'b1;
            default:                                   reads_rt = 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
            OP_LW, OP_LLB, OP_LHB, OP_PCS: writes_rd = 1'b1;
            default:                       writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic sets_flags(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: sets_flags = 1'b1;
            default:                                        sets_flags = 1'b0;
        endcase
    endfunction

    // ---------------- shadow EX/MEM scoreboard ----------------
    logic             ex_v_r,  mem_v_r;
    logic [OP_W-1:0]  ex_op_r, mem_op_r;
    logic [REG_W-1:0] ex_rd_r, mem_rd_r;

    state_t state_r, state_nx_s;

    logic miss_s;
    logic load_use_s;
    logic br_haz_s;
    logic b_haz_s;
    logic hazard_s;
    logic halt_entry_s;

    // Hazard detection against the shadow scoreboard.
    always_comb begin
        miss_s = icache_miss | dcache_miss;

        // A store whose only overlap with the load is its data register (rd)
        // is handled by MEM-to-MEM forwarding, so only rs/rt are checked.
        load_use_s = id_valid && ex_v_r && (ex_op_r == OP_LW) && (ex_rd_r != R0) &&
                     ((reads_rs(id_opcode) && (id_rs == ex_rd_r)) ||
                      (reads_rt(id_opcode) && (id_rt == ex_rd_r)));

        // BR reads rs in ID: an ALU result in EX costs one cycle, a load costs
        // two (first against EX, then against MEM).
        br_haz_s = id_valid && (id_opcode == OP_BR) && (id_rs != R0) &&
                   ((ex_v_r && writes_rd(ex_op_r) && (ex_rd_r == id_rs)) ||
                    (mem_v_r && (mem_op_r == OP_LW) && (mem_rd_r == id_rs)));

        // Conditional B must wait for flags from a flag setter still in EX.
        b_haz_s = id_valid && (id_opcode == OP_B) && (id_cond != 3'b111) &&
                  ex_v_r && sets_flags(ex_op_r);

        hazard_s     = load_use_s | br_haz_s | b_haz_s;
        halt_entry_s = id_valid && (id_opcode == OP_HLT) && !hazard_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN, ST_FREEZE: begin
                if (miss_s) begin
                    state_nx_s = ST_FREEZE;
                end else if (halt_entry_s) begin
                    state_nx_s = ST_HALT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALT: state_nx_s = ST_HALT;
            default: state_nx_s = ST_RUN;
        endcase
    end

    // FSM outputs. The freeze is raised combinationally in the cycle the miss
    // appears and drops in the cycle both misses clear, so RUN and FREEZE
    // share one decode driven by the live miss inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            case (state_r)
                ST_RUN, ST_FREEZE: begin
                    if (miss_s) begin
                        pipe_freeze = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                    end else if (hazard_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_valid && id_br_taken) begin
                        ifid_flush  = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted     = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (miss_s) begin
                        pipe_freeze = 1'b1;
                    end else begin
                        idex_bubble = 1'b1;
                    end
                end
                default: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // Shadow scoreboard advance; holds while the pipe is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_r   <= 1'b0;
            ex_op_r  <= OP_ADD;
            ex_rd_r  <= R0;
            mem_v_r  <= 1'b0;
            mem_op_r <= OP_ADD;
            mem_rd_r <= R0;
        end else if (!pipe_freeze) begin
            mem_v_r  <= ex_v_r;
            mem_op_r <= ex_op_r;
            mem_rd_r <= ex_rd_r;
            if (idex_bubble || !id_valid) begin
                ex_v_r <= 1'b0;
            end else begin
                ex_v_r  <= 1'b1;
                ex_op_r <= id_opcode;
                ex_rd_r <= id_rd;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= {CNT_W{1'b0}};
            freeze_cnt <= {CNT_W{1'b0}};
        end else begin
            if (idex_bubble && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pipe_freeze && (freeze_cnt != CNT_MAX)) begin
                freeze_cnt <= freeze_cnt + CNT_W'(1);
            end
        end
    end

endmodule
